// File: rtl/synth_voice_scheduler.sv
// Eight-channel note scheduler: allocates incoming notes to free channels, counts
// their duration in sample ticks, and serialises note-on/note-off events round-robin.
module synth_voice_scheduler (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        iTick,
  input  logic        iPause,
  input  logic        iNoteValid,
  input  logic [6:0]  iNotePitch,
  input  logic [6:0]  iNoteVolume,
  input  logic [3:0]  iNoteInst,
  input  logic [31:0] iNoteDuration,
  input  logic        iNoteMelody,
  output logic        oNoteReady,
  output logic        oEventValid,
  output logic        oEventOn,
  output logic [6:0]  oEventPitch,
  output logic [6:0]  oEventVolume,
  output logic [3:0]  oEventInst,
  input  logic        iEventReady,
  output logic [7:0]  oBusy,
  output logic        oMelodyBlock
);

  localparam int NCH = 8;

  logic [NCH-1:0]      w_occ;
  logic [NCH-1:0]      w_mel;
  logic [NCH-1:0]      w_onP;
  logic [NCH-1:0]      w_offP;
  logic [NCH-1:0]      w_pend;
  logic [NCH-1:0][6:0] w_pitch;
  logic [NCH-1:0][6:0] w_vol;
  logic [NCH-1:0][3:0] w_inst;

  logic       w_melBlock;
  logic       w_noteReady;
  logic       w_accept;
  logic       w_tickEn;
  logic       w_load;
  logic       w_grant;
  logic [2:0] w_allocIdx;
  logic [2:0] w_grantIdx;

  logic       r_evValid;
  logic       r_evOn;
  logic [6:0] r_evPitch;
  logic [6:0] r_evVol;
  logic [3:0] r_evInst;
  logic [2:0] r_rr;

  function automatic logic [31:0] sat_duration(input logic [31:0] d);
    sat_duration = (d == 32'd0) ? 32'd1 : d;
  endfunction

  function automatic logic [2:0] lowest_free(input logic [NCH-1:0] occ);
    lowest_free = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!occ[3'(i)]) lowest_free = 3'(i);
    end
  endfunction

  // Search starts just after the last grant; the last-granted channel is checked last.
  function automatic logic [2:0] rr_pick(input logic [NCH-1:0] pend, input logic [2:0] rr);
    logic [2:0] idx;
    rr_pick = rr;
    for (int k = NCH; k >= 1; k--) begin
      idx = rr + 3'(k);
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

  assign w_melBlock  = |(w_occ & w_mel);
  assign w_noteReady = (~&w_occ) & ~w_melBlock;
  assign w_accept    = iNoteValid & w_noteReady;
  assign w_allocIdx  = lowest_free(w_occ);
  assign w_tickEn    = iTick & ~iPause;
  assign w_pend      = w_onP | w_offP;
  assign w_load      = ~r_evValid | iEventReady;
  assign w_grant     = w_load & (|w_pend);
  assign w_grantIdx  = rr_pick(w_pend, r_rr);

  // Channel state: allocation, duration countdown, grant side effects
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic        r_occ;
    logic        r_mel;
    logic        r_onP;
    logic        r_offP;
    logic        r_run;
    logic [6:0]  r_pitch;
    logic [6:0]  r_vol;
    logic [3:0]  r_inst;
    logic [31:0] r_cnt;
    logic        w_alloc;
    logic        w_take;

    assign w_alloc = w_accept && (w_allocIdx == 3'(c));
    assign w_take  = w_grant && (w_grantIdx == 3'(c));

    // A freshly allocated channel is idle, so allocation never collides with a tick or grant.
    always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
        r_occ   <= 1'b0;
        r_mel   <= 1'b0;
        r_onP   <= 1'b0;
        r_offP  <= 1'b0;
        r_run   <= 1'b0;
        r_pitch <= '0;
        r_vol   <= '0;
        r_inst  <= '0;
        r_cnt   <= '0;
      end else if (w_alloc) begin
        r_occ   <= 1'b1;
        r_mel   <= iNoteMelody;
        r_onP   <= 1'b1;
        r_offP  <= 1'b0;
        r_run   <= 1'b0;
        r_pitch <= iNotePitch;
        r_vol   <= iNoteVolume;
        r_inst  <= iNoteInst;
        r_cnt   <= sat_duration(iNoteDuration);
      end else begin
        if (w_tickEn && r_run) begin
          if (r_cnt == 32'd1) begin
            r_cnt  <= 32'd0;
            r_run  <= 1'b0;
            r_offP <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        if (w_take) begin
          if (r_onP) begin
            r_onP <= 1'b0;
            r_run <= 1'b1;
          end else begin
            r_offP <= 1'b0;
            r_occ  <= 1'b0;
            r_mel  <= 1'b0;
          end
        end
      end
    end

    assign w_occ[c]   = r_occ;
    assign w_mel[c]   = r_mel;
    assign w_onP[c]   = r_onP;
    assign w_offP[c]  = r_offP;
    assign w_pitch[c] = r_pitch;
    assign w_vol[c]   = r_vol;
    assign w_inst[c]  = r_inst;
  end

  // Event output register: reloads only when empty or draining this cycle
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_evValid <= 1'b0;
      r_evOn    <= 1'b0;
      r_evPitch <= '0;
      r_evVol   <= '0;
      r_evInst  <= '0;
      r_rr      <= 3'd0;
    end else if (w_grant) begin
      r_evValid <= 1'b1;
      r_evOn    <= w_onP[w_grantIdx];
      r_evPitch <= w_pitch[w_grantIdx];
      r_evVol   <= w_onP[w_grantIdx] ? w_vol[w_grantIdx] : 7'd0;
      r_evInst  <= w_inst[w_grantIdx];
      r_rr      <= w_grantIdx;
    end else if (w_load) begin
      r_evValid <= 1'b0;
    end
  end

  assign oNoteReady   = w_noteReady;
  assign oMelodyBlock = w_melBlock;
  assign oBusy        = w_occ;
  assign oEventValid  = r_evValid;
  assign oEventOn     = r_evOn;
  assign oEventPitch  = r_evPitch;
  assign oEventVolume = r_evVol;
  assign oEventInst   = r_evInst;

endmodule

// File: tb/tb_synth_voice_scheduler.sv
// Bench for synth_voice_scheduler: directed scenarios plus random traffic, checked
// against a note-level reference model and an event scoreboard.
module tb_synth_voice_scheduler;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        iTick = 1'b0;
  logic        iPause = 1'b0;
  logic        iNoteValid = 1'b0;
  logic [6:0]  iNotePitch = '0;
  logic [6:0]  iNoteVolume = '0;
  logic [3:0]  iNoteInst = '0;
  logic [31:0] iNoteDuration = '0;
  logic        iNoteMelody = 1'b0;
  logic        iEventReady = 1'b1;
  logic        oNoteReady;
  logic        oEventValid;
  logic        oEventOn;
  logic [6:0]  oEventPitch;
  logic [6:0]  oEventVolume;
  logic [3:0]  oEventInst;
  logic [7:0]  oBusy;
  logic        oMelodyBlock;

  synth_voice_scheduler dut (
    .CLK(CLK), .Reset(Reset), .iTick(iTick), .iPause(iPause),
    .iNoteValid(iNoteValid), .iNotePitch(iNotePitch), .iNoteVolume(iNoteVolume),
    .iNoteInst(iNoteInst), .iNoteDuration(iNoteDuration), .iNoteMelody(iNoteMelody),
    .oNoteReady(oNoteReady), .oEventValid(oEventValid), .oEventOn(oEventOn),
    .oEventPitch(oEventPitch), .oEventVolume(oEventVolume), .oEventInst(oEventInst),
    .iEventReady(iEventReady), .oBusy(oBusy), .oMelodyBlock(oMelodyBlock)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per voice, events as (on, pitch, volume, inst)
  typedef struct {
    bit        occ, mel, onp, offp, run;
    bit [6:0]  pitch, vol;
    bit [3:0]  inst;
    bit [31:0] cnt;
  } chan_t;

  typedef struct packed {
    bit       on;
    bit [6:0] p;
    bit [6:0] v;
    bit [3:0] i;
  } ev_t;

  chan_t m[8];
  int    m_last;
  bit    m_valid;
  ev_t   m_ev;
  ev_t   sb[$];
  ev_t   e_pop;

  task automatic model_reset();
    for (int c = 0; c < 8; c++) m[c] = '{default: 0};
    m_last  = 0;
    m_valid = 0;
    m_ev    = '0;
  endtask

  task automatic model_step();
    bit [7:0] busy;
    bit       mb, rdy, xfer, load;
    int       g, a;
    chan_t    nx[8];
    busy = '0;
    mb   = 0;
    for (int c = 0; c < 8; c++) begin
      busy[c] = m[c].occ;
      if (m[c].occ && m[c].mel) mb = 1;
    end
    rdy = (busy != 8'hFF) && !mb;
    check("busy", oBusy, busy);
    check("melody_block", oMelodyBlock, mb);
    check("note_ready", oNoteReady, rdy);
    check("event_valid", oEventValid, m_valid);
    if (m_valid)
      check("event_payload", {oEventOn, oEventPitch, oEventVolume, oEventInst}, m_ev);
    xfer = m_valid && iEventReady;
    if (xfer) sb.push_back(m_ev);
    nx = m;
    if (iTick && !iPause) begin
      for (int c = 0; c < 8; c++) begin
        if (m[c].run) begin
          if (m[c].cnt == 1) begin
            nx[c].cnt  = 0;
            nx[c].run  = 0;
            nx[c].offp = 1;
          end else begin
            nx[c].cnt = m[c].cnt - 1;
          end
        end
      end
    end
    load = !m_valid || xfer;
    g = -1;
    if (load) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_last + k) % 8;
        if (g < 0 && (m[c].onp || m[c].offp)) g = c;
      end
    end
    if (g >= 0) begin
      m_valid = 1;
      m_last  = g;
      if (m[g].onp) begin
        m_ev = {1'b1, m[g].pitch, m[g].vol, m[g].inst};
        nx[g].onp = 0;
        nx[g].run = 1;
      end else begin
        m_ev = {1'b0, m[g].pitch, 7'd0, m[g].inst};
        nx[g].offp = 0;
        nx[g].occ  = 0;
        nx[g].mel  = 0;
      end
    end else if (load) begin
      m_valid = 0;
    end
    if (iNoteValid && rdy) begin
      a = -1;
      for (int c = 0; c < 8; c++) if (a < 0 && !m[c].occ) a = c;
      nx[a].occ   = 1;
      nx[a].mel   = iNoteMelody;
      nx[a].onp   = 1;
      nx[a].offp  = 0;
      nx[a].run   = 0;
      nx[a].pitch = iNotePitch;
      nx[a].vol   = iNoteVolume;
      nx[a].inst  = iNoteInst;
      nx[a].cnt   = (iNoteDuration == 0) ? 32'd1 : iNoteDuration;
    end
    m = nx;
  endtask

  always @(negedge CLK) begin
    if (Reset) begin
      model_reset();
      sb.delete();
      check("reset_outputs",
            {oEventValid, oEventOn, oEventPitch, oEventVolume, oEventInst, oBusy, oMelodyBlock, oNoteReady},
            {1'b0, 1'b0, 7'd0, 7'd0, 4'd0, 8'd0, 1'b0, 1'b1});
    end else begin
      model_step();
    end
  end

  // Scoreboard monitor: every transfer consumes the oldest expected event
  always @(negedge CLK) begin
    #1;
    if (!Reset && oEventValid && iEventReady) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got event %0h, expected none", {oEventOn, oEventPitch, oEventVolume, oEventInst});
      end else begin
        e_pop = sb.pop_front();
        check("sb_event", {oEventOn, oEventPitch, oEventVolume, oEventInst}, e_pop);
      end
    end
  end

  int tick_div = 0;
  int cyc = 0;
  always @(posedge CLK) begin
    #1;
    cyc++;
    iTick = (tick_div > 0) && (cyc % tick_div == 0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_note(input bit [6:0] p, input bit [6:0] v, input bit [3:0] ins,
                           input bit [31:0] dur, input bit mel, input int budget);
    bit acc;
    acc = 0;
    iNoteValid = 1; iNotePitch = p; iNoteVolume = v; iNoteInst = ins;
    iNoteDuration = dur; iNoteMelody = mel;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge CLK);
      acc = oNoteReady;
      @(posedge CLK);
      #1;
    end
    iNoteValid = 0;
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL note_accept_timeout: pitch %0d not accepted within %0d cycles", p, budget);
    end
  endtask

  initial begin
    #200000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1;
    check("reset_note_ready", oNoteReady, 1'b1);
    check("reset_busy", oBusy, 8'h00);
    step(3);
    Reset = 0;
    step(2);

    // Single note, duration 3
    tick_div = 4;
    send_note(7'd60, 7'd100, 4'd2, 32'd3, 1'b0, 10);
    step(30);
    check("single_busy_idle", oBusy, 8'h00);

    // Fill all channels, then a ninth note waits for an off-grant
    tick_div = 0;
    for (int i = 0; i < 8; i++) send_note(7'(10 + i), 7'(20 + i), 4'(i), 32'd1000, 1'b0, 10);
    step(12);
    check("fill_busy", oBusy, 8'hFF);
    check("fill_ready", oNoteReady, 1'b0);
    tick_div = 1;
    send_note(7'd99, 7'd33, 4'd9, 32'd5, 1'b0, 1200);
    step(40);

    // Melody note blocks acceptance until its off-event
    tick_div = 2;
    send_note(7'd70, 7'd50, 4'd1, 32'd4, 1'b1, 10);
    step(1);
    check("melody_blocks_ready", oNoteReady, 1'b0);
    send_note(7'd71, 7'd51, 4'd3, 32'd2, 1'b0, 100);
    step(20);

    // Backpressure with three pending events, volume 0 on one of them
    tick_div = 0;
    iEventReady = 0;
    send_note(7'd1, 7'd11, 4'd4, 32'd6, 1'b0, 10);
    send_note(7'd2, 7'd0, 4'd5, 32'd6, 1'b0, 10);
    send_note(7'd3, 7'd13, 4'd6, 32'd6, 1'b0, 10);
    step(6);
    check("bp_valid_held", oEventValid, 1'b1);
    iEventReady = 1;
    step(6);
    tick_div = 1;
    step(30);

    // Pause for 10 ticks mid-countdown, then duration 0
    send_note(7'd40, 7'd40, 4'd7, 32'd20, 1'b0, 10);
    step(5);
    iPause = 1;
    step(10);
    iPause = 0;
    step(40);
    send_note(7'd41, 7'd41, 4'd8, 32'd0, 1'b0, 10);
    step(10);

    // Reset with active notes and a blocked event
    tick_div = 0;
    iEventReady = 0;
    for (int i = 0; i < 4; i++) send_note(7'(80 + i), 7'(90 + i), 4'(i), 32'd1000, 1'b0, 10);
    step(3);
    Reset = 1;
    #1;
    check("async_reset_valid", oEventValid, 1'b0);
    check("async_reset_busy", oBusy, 8'h00);
    check("async_reset_payload", {oEventOn, oEventPitch, oEventVolume, oEventInst}, 19'd0);
    check("async_reset_ready", oNoteReady, 1'b1);
    step(2);
    Reset = 0;
    iEventReady = 1;
    tick_div = 1;
    step(30);

    // Random traffic
    tick_div = 2;
    for (int i = 0; i < 2500; i++) begin
      iNoteValid    = ($urandom_range(0, 99) < 40);
      iNotePitch    = 7'($urandom);
      iNoteVolume   = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom);
      iNoteInst     = 4'($urandom);
      iNoteDuration = 32'($urandom_range(0, 12));
      iNoteMelody   = ($urandom_range(0, 99) < 8);
      iEventReady   = ($urandom_range(0, 99) < 70);
      iPause        = ($urandom_range(0, 99) < 10);
      step(1);
    end

    iNoteValid = 0;
    iPause = 0;
    iEventReady = 1;
    tick_div = 1;
    step(80);
    check("drain_sb_empty", sb.size(), 0);
    check("drain_busy", oBusy, 8'h00);
    check("drain_valid", oEventValid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/synth_voice_scheduler.md
SYNTH_VOICE_SCHEDULER -- requirements
Module: synth_voice_scheduler

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port iTick, input, 1 bit: one-cycle sample-rate enable pulse.
REQ-004 SHALL have port iPause, input, 1 bit: freezes duration countdown when high.
REQ-005 SHALL have ports iNoteValid (in, 1), iNotePitch (in, 7), iNoteVolume (in, 7), iNoteInst (in, 4), iNoteDuration (in, 32, ticks) and iNoteMelody (in, 1): the note request.
REQ-006 SHALL have port oNoteReady, output, 1 bit: a note is accepted on a cycle where iNoteValid and oNoteReady are both high.
REQ-007 SHALL have ports oEventValid (out, 1), oEventOn (out, 1), oEventPitch (out, 7), oEventVolume (out, 7) and oEventInst (out, 4): the synth event.
REQ-008 SHALL have port iEventReady, input, 1 bit: an event transfers on a cycle where oEventValid and iEventReady are both high.
REQ-009 SHALL have port oBusy, output, 8 bits: channel-occupied flags.
REQ-010 SHALL have port oMelodyBlock, output, 1 bit: an occupied melody channel exists.

Function
REQ-011 SHALL hold 8 channels, each with: occupied, melody, onPending, offPending, running, pitch[6:0], volume[6:0], inst[3:0] and count[31:0].
REQ-012 SHALL drive oNoteReady = (any channel not occupied) AND NOT oMelodyBlock, combinationally.
REQ-013 SHALL allocate each accepted note to the lowest-index free channel, in the same cycle as acceptance.
REQ-014 SHALL, on acceptance, set occupied=1, onPending=1 and running=0, and store pitch, volume, inst, melody and count.
REQ-015 SHALL store count as iNoteDuration, except that a duration of 0 SHALL be stored as 1.
REQ-016 SHALL drive oMelodyBlock = OR over channels of (occupied AND melody).
REQ-017 SHALL, on an iTick cycle with iPause=0, decrement count for every channel with running=1.
REQ-018 SHALL, when a running channel ticks with count==1: set count=0, set running=0 and set offPending=1.
REQ-019 SHALL leave count unchanged for every channel while iPause=1, including on iTick cycles.
REQ-020 Arbiter: SHALL maintain a 3-bit round-robin pointer rr, reset value 0.
REQ-021 Arbiter: candidates SHALL be channels with onPending OR offPending; the search SHALL start at index rr+1 (mod 8).
REQ-022 Arbiter: SHALL load the output register only when oEventValid==0 or a transfer occurs this cycle, giving 1-cycle latency from a pending flag to oEventValid.
REQ-023 Arbiter: on grant, SHALL clear the granted channel's pending flag and set rr to the granted index.
REQ-024 On-event: oEventOn=1, with the channel's pitch, volume and inst; the channel's running flag SHALL be set when the grant is made.
REQ-025 Off-event: oEventOn=0, with the channel's pitch, oEventVolume=0 and the channel's inst; occupied and melody SHALL clear when the grant is made.
REQ-026 A channel SHALL never have onPending and offPending set together, because countdown starts only after the on-event is granted.
REQ-027 oEventValid SHALL stay high and the payload SHALL stay stable until a transfer; back-to-back transfers SHALL be sustainable at one per cycle.
REQ-028 A channel freed by an off-grant SHALL be reusable from the next cycle; acceptance in the same cycle as the freeing grant SHALL NOT target that channel.
REQ-029 Simultaneous acceptance, tick and grant on different channels SHALL all take effect in the same cycle.
REQ-030 A note with volume 0 SHALL be scheduled normally and issue an on-event with oEventVolume=0.

Reset
REQ-031 While Reset=1, asynchronously, SHALL clear all channel flags, counts and fields, and set rr=0.
REQ-032 While Reset=1, SHALL drive oEventValid=0, oEventOn=0, oEventPitch=0, oEventVolume=0, oEventInst=0, oBusy=0 and oMelodyBlock=0, with oNoteReady=1.
REQ-033 Reset asserted mid-operation SHALL discard all pending events and active notes, and SHALL emit no off-events afterwards.

Verification
REQ-034 Scenario (single note): accept pitch 60, vol 100, inst 2, duration 3, iEventReady=1 -> on-event(60,100,2) 1 cycle later; off-event(60,0,2) after the 3rd subsequent iTick; oBusy returns to 0.
REQ-035 Scenario (fill): accept 8 non-melody notes with duration 1000 -> oBusy=8'hFF, oNoteReady=0; 9th iNoteValid held with no acceptance until an off-grant, then it is allocated to the freed channel.
REQ-036 Scenario (melody): accept a melody note -> oMelodyBlock=1 and oNoteReady=0 until its off-event transfers; the next note is then accepted the following cycle.
REQ-037 Scenario (backpressure): hold iEventReady=0 with 3 notes pending -> oEventValid=1 with a constant payload; on release, events on channels 0,1,2 transfer in round-robin order on consecutive cycles.
REQ-038 Scenario (pause): during countdown, iPause=1 for 10 ticks -> count frozen and the off-event is delayed by exactly 10 ticks; duration 0 behaves as duration 1.
REQ-039 Scenario (reset): assert Reset with 4 channels active and an event pending -> all outputs reach their reset values immediately and no events follow after release.
